// File: rtl/membus_core_slave.sv
// membus_core_slave: 16K x 36 core memory module answering one select code on the processor memory bus.
// Bus bit 0 is the MSB: ma[21:35] -> membus_ma_p0[14:0], sel[18:21] -> [3:0], mb[0:35] -> [35:0].
// Optional feature: define MEMBUS_WR_TIMEOUT_EN to abandon a write cycle whose wr_rs never arrives.
module membus_core_slave #(
    parameter logic [3:0] memsel_p0  = 4'b0000,
    parameter int         wr_timeout = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        power,
    input  logic        membus_rq_cyc_p0,
    input  logic        membus_rd_rq_p0,
    input  logic        membus_wr_rq_p0,
    input  logic        membus_wr_rs_p0,
    input  logic [14:0] membus_ma_p0,
    input  logic [3:0]  membus_sel_p0,
    input  logic        membus_fmc_select_p0,
    input  logic [35:0] membus_mb_in_p0,
    output logic        membus_addr_ack_p0,
    output logic        membus_rd_rs_p0,
    output logic [35:0] membus_mb_out_p0,
    output logic        mem_timeout
);
    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] ACK    = 3'd1;
    localparam logic [2:0] READ   = 3'd2;
    localparam logic [2:0] WAITWR = 3'd3;
    localparam logic [2:0] DONE   = 3'd4;

`ifdef MEMBUS_WR_TIMEOUT_EN
    localparam logic timeout_en = 1'b1;
`else
    localparam logic timeout_en = 1'b0;
`endif
    localparam int cnt_w = $clog2(wr_timeout + 1);

    logic [35:0]      mem [0:16383];
    logic [2:0]       state;
    logic [2:0]       state_d;
    logic [13:0]      ma_q;
    logic             rd_q;
    logic             wr_q;
    logic [cnt_w-1:0] wr_cnt;
    logic             accept;
    logic             wr_en;
    logic             timeout_hit;
    logic             unused_ma21;

    // ma[21] is already decoded by the module select lines.
    assign unused_ma21 = membus_ma_p0[14];

    // Addresses 0-17 octal belong to the processor's fast memory when it is enabled.
    assign accept = power && membus_rq_cyc_p0 && (membus_rd_rq_p0 || membus_wr_rq_p0)
                 && (membus_sel_p0 == memsel_p0)
                 && !(membus_fmc_select_p0 && (membus_ma_p0[13:4] == 10'd0));

    assign timeout_hit = timeout_en && (state == WAITWR) && membus_rq_cyc_p0
                      && !membus_wr_rs_p0 && (wr_cnt == cnt_w'(wr_timeout - 1));

    assign wr_en = !reset && (state == WAITWR) && membus_rq_cyc_p0 && membus_wr_rs_p0;

    assign membus_addr_ack_p0 = (state == ACK);
    assign membus_rd_rs_p0    = (state == READ);

    always_comb begin
        // NOTE: a default assignment ahead of the case keeps this block free of inferred latches.
        state_d = state;
        case (state)
            IDLE:    if (accept) state_d = ACK;
            ACK:     if (!membus_rq_cyc_p0) state_d = IDLE;
                     else if (rd_q)         state_d = READ;
                     else                   state_d = WAITWR;
            READ:    if (!membus_rq_cyc_p0) state_d = IDLE;
                     else if (wr_q)         state_d = WAITWR;
                     else                   state_d = DONE;
            WAITWR:  if (!membus_rq_cyc_p0)                   state_d = IDLE;
                     else if (membus_wr_rs_p0 || timeout_hit) state_d = DONE;
            DONE:    if (!membus_rq_cyc_p0) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: the store has no reset; its contents must survive reset and a 16K-word clear cannot happen in one cycle.
    always_ff @(posedge clk) begin
        if (wr_en) mem[ma_q] <= membus_mb_in_p0;
    end

    // NOTE: all state updates use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state            <= IDLE;
            ma_q             <= '0;
            rd_q             <= 1'b0;
            wr_q             <= 1'b0;
            wr_cnt           <= '0;
            membus_mb_out_p0 <= '0;
            mem_timeout      <= 1'b0;
        end else begin
            state       <= state_d;
            mem_timeout <= timeout_hit;
            wr_cnt      <= (state == WAITWR) ? wr_cnt + cnt_w'(1) : '0;
            if (state == IDLE && accept) begin
                ma_q <= membus_ma_p0[13:0];
                rd_q <= membus_rd_rq_p0;
                wr_q <= membus_wr_rq_p0;
            end
            // Read data is held for the rest of the cycle and dropped on the way back to IDLE.
            if (state_d == IDLE)
                membus_mb_out_p0 <= '0;
            else if (state == ACK && state_d == READ)
                membus_mb_out_p0 <= mem[ma_q];
        end
    end
endmodule

// File: tb/tb_membus_core_slave.sv
// Directed bench for membus_core_slave: read, write, RMW, inhibit, abort, reset and write timeout.
// Bus bit 0 is the MSB, so octal constants map directly onto the [35:0] data and [14:0] address.
module tb_membus_core_slave;
    logic        clk = 1'b0;
    logic        reset;
    logic        power;
    logic        rq_cyc;
    logic        rd_rq;
    logic        wr_rq;
    logic        wr_rs;
    logic [14:0] ma;
    logic [3:0]  sel;
    logic        fmc;
    logic [35:0] mb_in;
    logic        addr_ack;
    logic        rd_rs;
    logic [35:0] mb_out;
    logic        mem_timeout;

    int n_vec = 0;
    int n_err = 0;

    membus_core_slave dut (
        .clk                  (clk),
        .reset                (reset),
        .power                (power),
        .membus_rq_cyc_p0     (rq_cyc),
        .membus_rd_rq_p0      (rd_rq),
        .membus_wr_rq_p0      (wr_rq),
        .membus_wr_rs_p0      (wr_rs),
        .membus_ma_p0         (ma),
        .membus_sel_p0        (sel),
        .membus_fmc_select_p0 (fmc),
        .membus_mb_in_p0      (mb_in),
        .membus_addr_ack_p0   (addr_ack),
        .membus_rd_rs_p0      (rd_rs),
        .membus_mb_out_p0     (mb_out),
        .mem_timeout          (mem_timeout)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [35:0] obs, input logic [35:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %o, expected %o", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_quiet(input string tag);
        check({tag, " addr_ack"}, 36'(addr_ack), 36'd0);
        check({tag, " rd_rs"}, 36'(rd_rs), 36'd0);
        check({tag, " mb_out"}, mb_out, 36'd0);
        check({tag, " mem_timeout"}, 36'(mem_timeout), 36'd0);
    endtask

    task automatic bus_write(input logic [14:0] addr, input logic [35:0] data, input string tag);
        ma = addr; rq_cyc = 1'b1; wr_rq = 1'b1;
        step();
        check({tag, " ack"}, 36'(addr_ack), 36'd1);
        wr_rq = 1'b0;
        step();
        check({tag, " ack end"}, 36'(addr_ack), 36'd0);
        check({tag, " no read"}, mb_out, 36'd0);
        wr_rs = 1'b1; mb_in = data;
        step();
        wr_rs = 1'b0; rq_cyc = 1'b0;
        check({tag, " no rd_rs"}, 36'(rd_rs), 36'd0);
        step();
    endtask

    task automatic bus_read(input logic [14:0] addr, input logic [35:0] exp, input string tag);
        ma = addr; rq_cyc = 1'b1; rd_rq = 1'b1;
        step();
        check({tag, " ack"}, 36'(addr_ack), 36'd1);
        check({tag, " rd_rs early"}, 36'(rd_rs), 36'd0);
        step();
        check({tag, " rd_rs"}, 36'(rd_rs), 36'd1);
        check({tag, " data"}, mb_out, exp);
        check({tag, " ack end"}, 36'(addr_ack), 36'd0);
        step();
        check({tag, " rd_rs end"}, 36'(rd_rs), 36'd0);
        check({tag, " data held"}, mb_out, exp);
        rq_cyc = 1'b0; rd_rq = 1'b0;
        step();
        check({tag, " data cleared"}, mb_out, 36'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int cnt;
        reset = 1'b1; power = 1'b1; rq_cyc = 1'b0; rd_rq = 1'b0; wr_rq = 1'b0; wr_rs = 1'b0;
        ma = '0; sel = 4'b0000; fmc = 1'b0; mb_in = '0;
        step();
        step();
        check_quiet("reset");
        reset = 1'b0;
        step();
        check_quiet("after reset");

        // Plain write then read back
        bus_write(15'o26, 36'o145000123456, "wr_26");
        bus_read(15'o26, 36'o145000123456, "rd_26");
        bus_write(15'o1002, 36'o201000000003, "wr_1002");
        bus_read(15'o1002, 36'o201000000003, "rd_1002");
        bus_write(15'o5, 36'o000000000555, "wr_5");

        // Read-modify-write at 20 octal, with fast memory enabled (20 is just above its range)
        bus_write(15'o20, 36'o200121000001, "wr_20");
        fmc = 1'b1; ma = 15'o20; rq_cyc = 1'b1; rd_rq = 1'b1; wr_rq = 1'b1;
        step();
        check("rmw ack", 36'(addr_ack), 36'd1);
        step();
        check("rmw rd_rs", 36'(rd_rs), 36'd1);
        check("rmw old data", mb_out, 36'o200121000001);
        step();
        check("rmw rd_rs end", 36'(rd_rs), 36'd0);
        check("rmw data held", mb_out, 36'o200121000001);
        wr_rs = 1'b1; mb_in = 36'o777777777777;
        step();
        wr_rs = 1'b0; rq_cyc = 1'b0; rd_rq = 1'b0; wr_rq = 1'b0; fmc = 1'b0;
        step();
        bus_read(15'o20, 36'o777777777777, "rmw readback");

        // ma[21] does not take part in addressing
        bus_read(15'o40026, 36'o145000123456, "ma21 ignored");

        // Fast-memory inhibit at 5 and at the top of the range (17), then release
        fmc = 1'b1; ma = 15'o5; rq_cyc = 1'b1; rd_rq = 1'b1;
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (addr_ack) cnt++;
        end
        check("fmc inhibit 5", 36'(cnt), 36'd0);
        ma = 15'o17;
        cnt = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (addr_ack) cnt++;
        end
        check("fmc inhibit 17", 36'(cnt), 36'd0);
        ma = 15'o5; fmc = 1'b0;
        step();
        check("fmc off ack", 36'(addr_ack), 36'd1);
        step();
        check("fmc off data", mb_out, 36'o000000000555);
        rq_cyc = 1'b0; rd_rq = 1'b0;
        step();
        check("abort in read clears", mb_out, 36'd0);

        // Wrong module select, then power off
        sel = 4'b0001; ma = 15'o26; rq_cyc = 1'b1; rd_rq = 1'b1;
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (addr_ack) cnt++;
        end
        check("sel mismatch", 36'(cnt), 36'd0);
        sel = 4'b0000; power = 1'b0;
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (addr_ack) cnt++;
        end
        check("power off", 36'(cnt), 36'd0);
        rq_cyc = 1'b0; rd_rq = 1'b0; power = 1'b1;
        step();

        // Power falling mid-cycle does not disturb the write
        ma = 15'o1002; rq_cyc = 1'b1; wr_rq = 1'b1;
        step();
        check("pwr drop ack", 36'(addr_ack), 36'd1);
        power = 1'b0;
        step();
        wr_rs = 1'b1; mb_in = 36'o000000000123;
        step();
        wr_rs = 1'b0; rq_cyc = 1'b0; wr_rq = 1'b0;
        step();
        power = 1'b1;
        bus_read(15'o1002, 36'o000000000123, "pwr drop readback");

        // rq_cyc dropped in WAITWR together with wr_rs, then a stray wr_rs in IDLE
        ma = 15'o1002; rq_cyc = 1'b1; rd_rq = 1'b1; wr_rq = 1'b1;
        step();
        step();
        step();
        check("abort waitwr data", mb_out, 36'o000000000123);
        rq_cyc = 1'b0; rd_rq = 1'b0; wr_rq = 1'b0; wr_rs = 1'b1; mb_in = 36'o444444444444;
        step();
        wr_rs = 1'b0;
        check_quiet("abort");
        step();
        wr_rs = 1'b1;
        step();
        wr_rs = 1'b0;
        step();
        bus_read(15'o1002, 36'o000000000123, "abort readback");

        // Reset in WAITWR with rq_cyc still high and wr_rs present
        ma = 15'o26; rq_cyc = 1'b1; wr_rq = 1'b1;
        step();
        step();
        reset = 1'b1; wr_rq = 1'b0; wr_rs = 1'b1; mb_in = 36'o707070707070;
        step();
        check_quiet("reset in waitwr");
        reset = 1'b0; rq_cyc = 1'b0;
        step();
        wr_rs = 1'b0;
        step();
        bus_read(15'o26, 36'o145000123456, "reset readback");

        // Write with no wr_rs: timeout after 64 WAITWR cycles, or wait forever
        ma = 15'o1002; rq_cyc = 1'b1; wr_rq = 1'b1;
        step();
        step();
        wr_rq = 1'b0;
        cnt = 0;
        for (int i = 0; i < 63; i++) begin
            step();
            if (mem_timeout) cnt++;
        end
        check("no early timeout", 36'(cnt), 36'd0);
        step();
`ifdef MEMBUS_WR_TIMEOUT_EN
        check("timeout pulse", 36'(mem_timeout), 36'd1);
        step();
        check("timeout one cycle", 36'(mem_timeout), 36'd0);
        wr_rs = 1'b1; mb_in = 36'o525252525252;
        step();
        wr_rs = 1'b0; rq_cyc = 1'b0;
        step();
        bus_read(15'o1002, 36'o000000000123, "timeout readback");
`else
        check("no timeout at 64", 36'(mem_timeout), 36'd0);
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (mem_timeout) cnt++;
        end
        check("no timeout later", 36'(cnt), 36'd0);
        wr_rs = 1'b1; mb_in = 36'o525252525252;
        step();
        wr_rs = 1'b0; rq_cyc = 1'b0;
        step();
        bus_read(15'o1002, 36'o525252525252, "late write readback");
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
